// File: rtl/clone_detect.sv
// Power-on famiclone detector: grounds CIRAM /CE and PPU /A13 for a fixed window, then
// samples PPU reads for A13 vs /A13 disagreement and latches a thresholded, re-armable verdict.
module clone_detect #(
    parameter int INIT_CYCLES        = 15,
    parameter int SETTLE_CYCLES      = 4,
    parameter int SAMPLES            = 3,
    parameter int MISMATCH_THRESHOLD = 1
) (
    input  logic       m2,
    input  logic       rst_n,
    input  logic       ppu_rd_in,
    input  logic       ppu_addr13,
    input  logic       ppu_not_a13,
    input  logic       rearm,
    output logic       drive_low,
    output logic       init_done,
    output logic       detect_valid,
    output logic       new_dendy,
    output logic [7:0] mismatch_count
);

    localparam int INIT_W   = $clog2(INIT_CYCLES + 1);
    localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int SAMP_W   = $clog2(SAMPLES + 1);

    // A zero settle time still spends one cycle in SETTLE before sampling.
    localparam int SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [INIT_W-1:0]   INIT_LAST   = INIT_W'(INIT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_LAST_I);
    localparam logic [SAMP_W-1:0]   SAMP_FULL   = SAMP_W'(SAMPLES);
    localparam logic [7:0]          MM_THRESH   = 8'(MISMATCH_THRESHOLD);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]          sync1;
    logic [2:0]          sync2;
    logic                rd_s;
    logic                a13_s;
    logic                na13_s;
    logic [INIT_W-1:0]   init_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SAMP_W-1:0]   lo_cnt;
    logic [SAMP_W-1:0]   hi_cnt;
    logic                init_last;
    logic                settle_last;
    logic                lo_full;
    logic                hi_full;
    logic                mm_hit;
    logic                decide;
    logic                sample_en;
    logic                is_mismatch;
    logic                rearm_done;

    // Synchroniser resets to the idle bus pattern (/RD high) so no phantom read is seen.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b101;
            sync2 <= 3'b101;
        end else begin
            sync1 <= {ppu_rd_in, ppu_addr13, ppu_not_a13};
            sync2 <= sync1;
        end
    end

    assign rd_s   = sync2[2];
    assign a13_s  = sync2[1];
    assign na13_s = sync2[0];

    assign init_last   = (init_cnt == INIT_LAST);
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign lo_full     = (lo_cnt == SAMP_FULL);
    assign hi_full     = (hi_cnt == SAMP_FULL);
    assign mm_hit      = (mismatch_count >= MM_THRESH);
    assign decide      = mm_hit || (lo_full && hi_full);
    assign is_mismatch = (a13_s == na13_s);
    assign rearm_done  = (state == ST_DONE) && rearm;
    // Samples stop once a verdict is pending so the reported count is the deciding one.
    assign sample_en   = (state == ST_SAMPLE) && !decide && !rd_s;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:   if (init_last)   state_next = ST_SETTLE;
            ST_SETTLE: if (settle_last) state_next = ST_SAMPLE;
            ST_SAMPLE: if (decide)      state_next = ST_DONE;
            ST_DONE:   if (rearm)       state_next = ST_SETTLE;
            default:                    state_next = ST_INIT;
        endcase
    end

    always_comb begin
        drive_low    = (state == ST_INIT);
        init_done    = (state != ST_INIT);
        detect_valid = (state == ST_DONE);
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt       <= '0;
            settle_cnt     <= '0;
            lo_cnt         <= '0;
            hi_cnt         <= '0;
            mismatch_count <= '0;
            new_dendy      <= 1'b0;
        end else begin
            if ((state == ST_INIT) && !init_last) begin
                init_cnt <= init_cnt + 1'b1;
            end

            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            if (rearm_done) begin
                lo_cnt         <= '0;
                hi_cnt         <= '0;
                mismatch_count <= '0;
            end else if (sample_en) begin
                if (a13_s && !hi_full) begin
                    hi_cnt <= hi_cnt + 1'b1;
                end
                if (!a13_s && !lo_full) begin
                    lo_cnt <= lo_cnt + 1'b1;
                end
                if (is_mismatch && (mismatch_count != 8'hFF)) begin
                    mismatch_count <= mismatch_count + 8'd1;
                end
            end

            // Mismatch threshold wins over level completion when both land together.
            if ((state == ST_SAMPLE) && decide) begin
                new_dendy <= mm_hit;
            end
        end
    end

endmodule

// File: tb/tb_clone_detect.sv
// Directed bench for clone_detect: two instances (threshold 1 and 3) driven with
// hand-computed read sequences; verdicts checked against an expected queue.
module tb_clone_detect;

    logic       m2    = 1'b0;
    logic       rst_n = 1'b0;

    logic       rd_a = 1'b1, a13_a = 1'b0, na13_a = 1'b1, rearm_a = 1'b0;
    logic       dl_a, id_a, dv_a, nd_a;
    logic [7:0] mm_a;

    logic       rd_b = 1'b1, a13_b = 1'b0, na13_b = 1'b1, rearm_b = 1'b0;
    logic       dl_b, id_b, dv_b, nd_b;
    logic [7:0] mm_b;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    clone_detect dut_a (
        .m2(m2), .rst_n(rst_n), .ppu_rd_in(rd_a), .ppu_addr13(a13_a),
        .ppu_not_a13(na13_a), .rearm(rearm_a), .drive_low(dl_a), .init_done(id_a),
        .detect_valid(dv_a), .new_dendy(nd_a), .mismatch_count(mm_a)
    );

    clone_detect #(.MISMATCH_THRESHOLD(3)) dut_b (
        .m2(m2), .rst_n(rst_n), .ppu_rd_in(rd_b), .ppu_addr13(a13_b),
        .ppu_not_a13(na13_b), .rearm(rearm_b), .drive_low(dl_b), .init_done(id_b),
        .detect_valid(dv_b), .new_dendy(nd_b), .mismatch_count(mm_b)
    );

    always #5 m2 = ~m2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge m2);
    endtask

    // One read spanning exactly one rising edge of m2.
    task automatic read_pin(input bit sel, input logic a13, input logic na13);
        @(negedge m2);
        if (sel) begin
            rd_b = 1'b0; a13_b = a13; na13_b = na13;
        end else begin
            rd_a = 1'b0; a13_a = a13; na13_a = na13;
        end
        @(negedge m2);
        if (sel) rd_b = 1'b1;
        else     rd_a = 1'b1;
    endtask

    task automatic rearm_pulse(input bit sel);
        @(negedge m2);
        if (sel) rearm_b = 1'b1;
        else     rearm_a = 1'b1;
        @(negedge m2);
        rearm_b = 1'b0;
        rearm_a = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dl_a"}, dl_a, 1'b1);
        check({tag, "_id_a"}, id_a, 1'b0);
        check({tag, "_dv_a"}, dv_a, 1'b0);
        check({tag, "_nd_a"}, nd_a, 1'b0);
        check({tag, "_mm_a"}, mm_a, 8'd0);
        check({tag, "_dl_b"}, dl_b, 1'b1);
        check({tag, "_id_b"}, id_b, 1'b0);
        check({tag, "_dv_b"}, dv_b, 1'b0);
        check({tag, "_nd_b"}, nd_b, 1'b0);
        check({tag, "_mm_b"}, mm_b, 8'd0);
    endtask

    // Called right after rst_n rises on a falling edge; counts cycles with drive_low high.
    task automatic count_init(input string tag);
        int hi_a = 0;
        int hi_b = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (dl_a) hi_a++;
            if (dl_b) hi_b++;
            @(negedge m2);
        end
        check({tag, "_len_a"}, hi_a, 15);
        check({tag, "_len_b"}, hi_b, 15);
        check({tag, "_done_a"}, id_a, 1'b1);
        check({tag, "_done_b"}, id_b, 1'b1);
    endtask

    // Verdict must appear on the third rising edge after the deciding read.
    task automatic finish_verdict(input bit sel, input string tag, input logic prev_nd);
        logic [8:0] e;
        @(posedge m2); #1;
        check({tag, "_dv_k1"}, sel ? dv_b : dv_a, 1'b0);
        @(posedge m2); #1;
        check({tag, "_dv_k2"}, sel ? dv_b : dv_a, 1'b0);
        check({tag, "_nd_k2"}, sel ? nd_b : nd_a, prev_nd);
        @(posedge m2); #1;
        e = exp_q.pop_front();
        check({tag, "_dv"}, sel ? dv_b : dv_a, 1'b1);
        check({tag, "_nd"}, sel ? nd_b : nd_a, e[8]);
        check({tag, "_mm"}, sel ? mm_b : mm_a, e[7:0]);
    endtask

    initial begin
        idle(2);
        check_reset_vals("rst");
        @(negedge m2);
        rst_n = 1'b1;
        count_init("init");
        idle(50);
        check("noread_dv_a", dv_a, 1'b0);
        check("noread_dv_b", dv_b, 1'b0);

        // Normal console on threshold-1 instance.
        exp_q.push_back({1'b0, 8'd0});
        repeat (3) read_pin(0, 1'b0, 1'b1);
        repeat (3) read_pin(0, 1'b1, 1'b0);
        finish_verdict(0, "normal", 1'b0);

        // Threshold 3: two mismatches among six samples is not a clone.
        exp_q.push_back({1'b0, 8'd2});
        read_pin(1, 1'b0, 1'b1);
        read_pin(1, 1'b0, 1'b0);
        read_pin(1, 1'b0, 1'b1);
        read_pin(1, 1'b1, 1'b0);
        read_pin(1, 1'b1, 1'b1);
        read_pin(1, 1'b1, 1'b0);
        finish_verdict(1, "thr_two", 1'b0);

        rearm_pulse(1);
        check("thr_rearm_dv", dv_b, 1'b0);
        check("thr_rearm_mm", mm_b, 8'd0);
        idle(5);
        // Third mismatch lands together with level completion: clone must win.
        exp_q.push_back({1'b1, 8'd3});
        read_pin(1, 1'b0, 1'b1);
        read_pin(1, 1'b0, 1'b0);
        read_pin(1, 1'b0, 1'b1);
        read_pin(1, 1'b1, 1'b0);
        read_pin(1, 1'b1, 1'b1);
        read_pin(1, 1'b1, 1'b1);
        finish_verdict(1, "thr_three", 1'b0);

        @(negedge m2);
        rst_n = 1'b0;
        idle(2);
        check_reset_vals("rst2");
        @(negedge m2);
        rst_n = 1'b1;
        idle(20);

        // Clone: /A13 stuck high, first A13=1 read decides.
        exp_q.push_back({1'b1, 8'd1});
        read_pin(0, 1'b0, 1'b1);
        read_pin(0, 1'b1, 1'b1);
        finish_verdict(0, "clone", 1'b0);

        rearm_pulse(0);
        check("rearm_dv", dv_a, 1'b0);
        check("rearm_nd", nd_a, 1'b1);
        check("rearm_mm", mm_a, 8'd0);
        check("rearm_dl", dl_a, 1'b0);
        idle(5);
        exp_q.push_back({1'b0, 8'd0});
        repeat (3) read_pin(0, 1'b0, 1'b1);
        check("rearm_mid_dl", dl_a, 1'b0);
        repeat (3) read_pin(0, 1'b1, 1'b0);
        finish_verdict(0, "rearm", 1'b1);
        check("rearm_end_dl", dl_a, 1'b0);
        check("rearm_end_id", id_a, 1'b1);

        // Asynchronous reset while the threshold-3 instance is mid-sampling.
        read_pin(1, 1'b0, 1'b0);
        idle(3);
        check("pre_async_mm_b", mm_b, 8'd1);
        check("pre_async_dl_b", dl_b, 1'b0);
        check("pre_async_dv_b", dv_b, 1'b0);
        @(posedge m2);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        idle(1);
        @(negedge m2);
        rst_n = 1'b1;
        count_init("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
